// File: rtl/a2_bridge_pkg.sv
// Shared constants and types for the Apple II slot bridge target.
package a2_bridge_pkg;

   typedef logic [2:0] bridge_sel_t;

   localparam bridge_sel_t BRIDGE_SEL_CTRL    = 3'd0;
   localparam bridge_sel_t BRIDGE_SEL_DATA    = 3'd1;
   localparam bridge_sel_t BRIDGE_SEL_ADDR_LO = 3'd2;
   localparam bridge_sel_t BRIDGE_SEL_ADDR_HI = 3'd3;
   localparam bridge_sel_t BRIDGE_SEL_MEM2    = 3'd4;
   localparam bridge_sel_t BRIDGE_SEL_DIP     = 3'd5;
   localparam bridge_sel_t BRIDGE_SEL_LB_DOUT = 3'd6;
   localparam bridge_sel_t BRIDGE_SEL_LB_CTRL = 3'd7;

   localparam int unsigned CTRL_IRQ_BIT = 2;
   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned LOST_W       = 6;

   // Address-phase snapshot taken while phi0 is low.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw_n;
      logic              m2sel_n;
      logic              m2b0;
   } a2_addr_snap_t;

   localparam a2_addr_snap_t ADDR_SNAP_RESET = '{addr: '0, rw_n: 1'b1, m2sel_n: 1'b0, m2b0: 1'b0};

endpackage

// File: rtl/a2_bridge_sync.sv
// Vector synchronizer: STAGES flops per bit, async active-low reset to 0.
// Ports: i_clk, i_rst_n, i_d (raw async input), o_q (synchronized output).
module a2_bridge_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < int'(STAGES); i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/a2_bridge_target.sv
// Target end of the muxed 8-bit bridge port. Snapshots the Apple II slot
// signals phase-aligned to phi0, returns the selected byte combinationally,
// and holds the control/data-out latches written by the bridge master.
// Optional macro A2_BRIDGE_LOOPBACK_EN: sel6/sel7 read back dout/ctrl.
// Ports:
//   clk_logic, device_reset_n          clock, async active-low reset
//   bridge_sel_i/rd_n_i/wr_n_i/d_i     bridge master request
//   bridge_d_o, bridge_d_oe_o          bridge read data and drive enable
//   bus_d_oe_n_i                       master request to drive slot data
//   a2_* inputs, gpio_in_i, dip_n_i    raw slot-side inputs
//   a2_data_o/a2_data_oe_o             slot data drive
//   a2_irq_oe_o                        open-drain IRQ pull-low enable
//   phase_lost_o                       no phi0 activity seen
module a2_bridge_target
   import a2_bridge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOST_COUNT  = 63
) (
   input  logic        clk_logic,
   input  logic        device_reset_n,
   input  logic [2:0]  bridge_sel_i,
   input  logic        bridge_rd_n_i,
   input  logic        bridge_wr_n_i,
   input  logic [7:0]  bridge_d_i,
   output logic [7:0]  bridge_d_o,
   output logic        bridge_d_oe_o,
   input  logic        bus_d_oe_n_i,
   input  logic        a2_phi0_i,
   input  logic [15:0] a2_addr_i,
   input  logic [7:0]  a2_data_i,
   input  logic        a2_rw_n_i,
   input  logic        a2_m2sel_n_i,
   input  logic        a2_m2b0_i,
   input  logic [7:0]  gpio_in_i,
   input  logic [3:0]  dip_n_i,
   output logic [7:0]  a2_data_o,
   output logic        a2_data_oe_o,
   output logic        a2_irq_oe_o,
   output logic        phase_lost_o
);

   localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_COUNT);

   logic              w_phi0_s;
   logic [ADDR_W-1:0] w_addr_s;
   logic [BYTE_W-1:0] w_data_s;
   logic [2:0]        w_ctl_s;
   logic [BYTE_W-1:0] w_gpio_s;
   logic [3:0]        w_dip_s;
   logic              w_phi0_rise;
   logic              w_phi0_fall;
   logic [BYTE_W-1:0] w_rd_data;

   logic              r_phi0_d;
   a2_addr_snap_t     r_asnap;
   logic [BYTE_W-1:0] r_data;
   logic [BYTE_W-1:0] r_ctrl;
   logic [BYTE_W-1:0] r_dout;
   logic [LOST_W-1:0] r_lost_cnt;

   // One synchronizer per input group.
   a2_bridge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_phi0 (
      .i_clk(clk_logic), .i_rst_n(device_reset_n), .i_d(a2_phi0_i), .o_q(w_phi0_s));
   a2_bridge_sync #(.WIDTH(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_addr (
      .i_clk(clk_logic), .i_rst_n(device_reset_n), .i_d(a2_addr_i), .o_q(w_addr_s));
   a2_bridge_sync #(.WIDTH(BYTE_W), .STAGES(SYNC_STAGES)) u_sync_data (
      .i_clk(clk_logic), .i_rst_n(device_reset_n), .i_d(a2_data_i), .o_q(w_data_s));
   a2_bridge_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_ctl (
      .i_clk(clk_logic), .i_rst_n(device_reset_n),
      .i_d({a2_rw_n_i, a2_m2sel_n_i, a2_m2b0_i}), .o_q(w_ctl_s));
   a2_bridge_sync #(.WIDTH(BYTE_W), .STAGES(SYNC_STAGES)) u_sync_gpio (
      .i_clk(clk_logic), .i_rst_n(device_reset_n), .i_d(gpio_in_i), .o_q(w_gpio_s));
   a2_bridge_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_dip (
      .i_clk(clk_logic), .i_rst_n(device_reset_n), .i_d(dip_n_i), .o_q(w_dip_s));

   assign w_phi0_rise = w_phi0_s & ~r_phi0_d;
   assign w_phi0_fall = ~w_phi0_s & r_phi0_d;

   // Phase-aligned snapshots: address phase tracks while phi0 low, data while high.
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) begin
         r_phi0_d <= 1'b0;
         r_asnap  <= ADDR_SNAP_RESET;
         r_data   <= '0;
      end else begin
         r_phi0_d <= w_phi0_s;
         if (!w_phi0_s) begin
            r_asnap.addr    <= w_addr_s;
            r_asnap.rw_n    <= w_ctl_s[2];
            r_asnap.m2sel_n <= w_ctl_s[1];
            r_asnap.m2b0    <= w_ctl_s[0];
         end
         if (w_phi0_s) r_data <= w_data_s;
      end
   end

   // Level-sampled bridge writes; a held strobe just rewrites the same value.
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) begin
         r_ctrl <= 8'hFF;
         r_dout <= '0;
      end else if (!bridge_wr_n_i) begin
         if (bridge_sel_i == BRIDGE_SEL_CTRL) r_ctrl <= bridge_d_i;
         if (bridge_sel_i == BRIDGE_SEL_DATA) r_dout <= bridge_d_i;
      end
   end

   // Phase watchdog, saturating at LOST_COUNT.
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) begin
         r_lost_cnt <= LOST_MAX;
      end else if (w_phi0_rise || w_phi0_fall) begin
         r_lost_cnt <= '0;
      end else if (r_lost_cnt != LOST_MAX) begin
         r_lost_cnt <= r_lost_cnt + LOST_W'(1);
      end
   end

   // Zero-latency read mux.
   always_comb begin
      w_rd_data = 8'hFF;
      case (bridge_sel_t'(bridge_sel_i))
         BRIDGE_SEL_CTRL:    w_rd_data = {w_gpio_s[7:1], r_asnap.rw_n};
         BRIDGE_SEL_DATA:    w_rd_data = r_data;
         BRIDGE_SEL_ADDR_LO: w_rd_data = r_asnap.addr[7:0];
         BRIDGE_SEL_ADDR_HI: w_rd_data = r_asnap.addr[15:8];
         BRIDGE_SEL_MEM2:    w_rd_data = {6'b0, r_asnap.m2sel_n, r_asnap.m2b0};
         BRIDGE_SEL_DIP:     w_rd_data = {4'hF, w_dip_s};
`ifdef A2_BRIDGE_LOOPBACK_EN
         BRIDGE_SEL_LB_DOUT: w_rd_data = r_dout;
         BRIDGE_SEL_LB_CTRL: w_rd_data = r_ctrl;
`else
         BRIDGE_SEL_LB_DOUT,
         BRIDGE_SEL_LB_CTRL: w_rd_data = 8'hFF;
`endif
      endcase
   end

   assign bridge_d_o    = w_rd_data;
   // Write strobe suppresses read drive so the shared bus never contends.
   assign bridge_d_oe_o = !bridge_rd_n_i && bridge_wr_n_i;
   assign a2_irq_oe_o   = !r_ctrl[CTRL_IRQ_BIT];
   assign a2_data_o     = r_dout;
   // Drive only on Apple II read cycles during phi0 high; drops with phi0_s.
   assign a2_data_oe_o  = !bus_d_oe_n_i && w_phi0_s && r_asnap.rw_n;
   assign phase_lost_o  = (r_lost_cnt == LOST_MAX);

   // gpio bit0 is replaced by rw_n; most ctrl bits only matter for loopback.
   logic w_unused;
   assign w_unused = &{1'b0, w_gpio_s[0], r_ctrl};

endmodule

// File: tb/tb_a2_bridge_target.sv
// Directed self-checking bench for a2_bridge_target.
module tb_a2_bridge_target;

   logic        clk_logic = 1'b0;
   logic        device_reset_n;
   logic [2:0]  bridge_sel_i;
   logic        bridge_rd_n_i;
   logic        bridge_wr_n_i;
   logic [7:0]  bridge_d_i;
   logic [7:0]  bridge_d_o;
   logic        bridge_d_oe_o;
   logic        bus_d_oe_n_i;
   logic        a2_phi0_i;
   logic [15:0] a2_addr_i;
   logic [7:0]  a2_data_i;
   logic        a2_rw_n_i;
   logic        a2_m2sel_n_i;
   logic        a2_m2b0_i;
   logic [7:0]  gpio_in_i;
   logic [3:0]  dip_n_i;
   logic [7:0]  a2_data_o;
   logic        a2_data_oe_o;
   logic        a2_irq_oe_o;
   logic        phase_lost_o;

   int checks = 0;
   int errors = 0;

   a2_bridge_target #(.SYNC_STAGES(2), .LOST_COUNT(63)) dut (
      .clk_logic(clk_logic), .device_reset_n(device_reset_n),
      .bridge_sel_i(bridge_sel_i), .bridge_rd_n_i(bridge_rd_n_i),
      .bridge_wr_n_i(bridge_wr_n_i), .bridge_d_i(bridge_d_i),
      .bridge_d_o(bridge_d_o), .bridge_d_oe_o(bridge_d_oe_o),
      .bus_d_oe_n_i(bus_d_oe_n_i), .a2_phi0_i(a2_phi0_i),
      .a2_addr_i(a2_addr_i), .a2_data_i(a2_data_i), .a2_rw_n_i(a2_rw_n_i),
      .a2_m2sel_n_i(a2_m2sel_n_i), .a2_m2b0_i(a2_m2b0_i),
      .gpio_in_i(gpio_in_i), .dip_n_i(dip_n_i),
      .a2_data_o(a2_data_o), .a2_data_oe_o(a2_data_oe_o),
      .a2_irq_oe_o(a2_irq_oe_o), .phase_lost_o(phase_lost_o));

   always #5 clk_logic = ~clk_logic;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advance n clocks and settle 1ns past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_logic);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, input string tag, input logic [7:0] exp);
      bridge_sel_i  = sel;
      bridge_rd_n_i = 1'b0;
      #1;
      chk(tag, 16'(bridge_d_o), 16'(exp));
      bridge_rd_n_i = 1'b1;
      #1;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [7:0] d);
      bridge_sel_i  = sel;
      bridge_d_i    = d;
      bridge_wr_n_i = 1'b0;
      tick(1);
      bridge_wr_n_i = 1'b1;
      #1;
   endtask

   initial begin
      device_reset_n = 1'b0;
      bridge_sel_i   = 3'd0;
      bridge_rd_n_i  = 1'b1;
      bridge_wr_n_i  = 1'b1;
      bridge_d_i     = 8'h00;
      bus_d_oe_n_i   = 1'b1;
      a2_phi0_i      = 1'b0;
      a2_addr_i      = 16'h0000;
      a2_data_i      = 8'h00;
      a2_rw_n_i      = 1'b1;
      a2_m2sel_n_i   = 1'b1;
      a2_m2b0_i      = 1'b0;
      gpio_in_i      = 8'h00;
      dip_n_i        = 4'hF;

      // Reset state
      tick(2);
      chk("rst_irq_oe", 16'(a2_irq_oe_o), 16'd0);
      chk("rst_data_o", 16'(a2_data_o), 16'h00);
      chk("rst_data_oe", 16'(a2_data_oe_o), 16'd0);
      chk("rst_bridge_oe", 16'(bridge_d_oe_o), 16'd0);
      chk("rst_phase_lost", 16'(phase_lost_o), 16'd1);
      rd(3'd0, "rst_sel0", 8'h01);
      rd(3'd5, "rst_sel5", 8'hF0);
      bridge_rd_n_i = 1'b0;
      #1;
      chk("rd_oe_on", 16'(bridge_d_oe_o), 16'd1);
      bridge_rd_n_i = 1'b1;
      #1;
      device_reset_n = 1'b1;

      // Watchdog: static phi0 keeps it lost, first edge clears after sync delay
      tick(3);
      chk("wd_static", 16'(phase_lost_o), 16'd1);
      a2_phi0_i = 1'b1;
      tick(2);
      chk("wd_sync_delay", 16'(phase_lost_o), 16'd1);
      tick(1);
      chk("wd_cleared", 16'(phase_lost_o), 16'd0);
      tick(62);
      chk("wd_cnt62", 16'(phase_lost_o), 16'd0);
      tick(1);
      chk("wd_lost63", 16'(phase_lost_o), 16'd1);

      // Address capture
      gpio_in_i    = 8'hA5;
      dip_n_i      = 4'h6;
      a2_m2sel_n_i = 1'b0;
      a2_m2b0_i    = 1'b1;
      a2_phi0_i    = 1'b0;
      a2_addr_i    = 16'hC0E1;
      a2_rw_n_i    = 1'b0;
      tick(5);
      a2_phi0_i = 1'b1;
      tick(5);
      a2_addr_i    = 16'h1234;
      a2_rw_n_i    = 1'b1;
      a2_m2sel_n_i = 1'b1;
      a2_m2b0_i    = 1'b0;
      tick(5);
      rd(3'd2, "addr_lo", 8'hE1);
      rd(3'd3, "addr_hi", 8'hC0);
      rd(3'd0, "sel0_rw", 8'hA4);
      rd(3'd4, "mem2", 8'h01);
      rd(3'd5, "dip", 8'hF6);

      // Data capture
      a2_data_i = 8'hA5;
      tick(5);
      a2_phi0_i = 1'b0;
      tick(5);
      a2_data_i = 8'h00;
      tick(5);
      rd(3'd1, "data_frozen", 8'hA5);
      rd(3'd2, "addr_lo_reload", 8'h34);
      rd(3'd4, "mem2_reload", 8'h02);

      // Writes
      wr(3'd0, 8'hFB);
      chk("irq_on", 16'(a2_irq_oe_o), 16'd1);
      wr(3'd1, 8'h5A);
      chk("dout", 16'(a2_data_o), 16'h5A);
      bus_d_oe_n_i = 1'b0;
      tick(1);
      chk("oe_phi0_low", 16'(a2_data_oe_o), 16'd0);
      a2_phi0_i = 1'b1;
      tick(5);
      chk("oe_on", 16'(a2_data_oe_o), 16'd1);
      a2_phi0_i = 1'b0;
      tick(1);
      chk("oe_hold_sync", 16'(a2_data_oe_o), 16'd1);
      tick(1);
      chk("oe_drop", 16'(a2_data_oe_o), 16'd0);
      bus_d_oe_n_i = 1'b1;

      // Contention and ignored selects
      wr(3'd0, 8'hFF);
      chk("irq_off", 16'(a2_irq_oe_o), 16'd0);
      bridge_sel_i  = 3'd0;
      bridge_d_i    = 8'h00;
      bridge_rd_n_i = 1'b0;
      bridge_wr_n_i = 1'b0;
      #1;
      chk("contention_oe", 16'(bridge_d_oe_o), 16'd0);
      tick(1);
      bridge_rd_n_i = 1'b1;
      bridge_wr_n_i = 1'b1;
      #1;
      chk("contention_wr", 16'(a2_irq_oe_o), 16'd1);
      wr(3'd4, 8'hFF);
      chk("sel4_ctrl", 16'(a2_irq_oe_o), 16'd1);
      chk("sel4_dout", 16'(a2_data_o), 16'h5A);

      // Loopback
      wr(3'd1, 8'h3C);
      chk("dout_3c", 16'(a2_data_o), 16'h3C);
`ifdef A2_BRIDGE_LOOPBACK_EN
      rd(3'd6, "lb_dout", 8'h3C);
      rd(3'd7, "lb_ctrl", 8'h00);
`else
      rd(3'd6, "sel6_ff", 8'hFF);
      rd(3'd7, "sel7_ff", 8'hFF);
`endif

      // Reset mid-write wins, held strobe captured after deassertion
      bridge_sel_i   = 3'd0;
      bridge_d_i     = 8'h00;
      bridge_wr_n_i  = 1'b0;
      #1;
      device_reset_n = 1'b0;
      #1;
      chk("rst_mid_irq", 16'(a2_irq_oe_o), 16'd0);
      chk("rst_mid_dout", 16'(a2_data_o), 16'h00);
      chk("rst_mid_lost", 16'(phase_lost_o), 16'd1);
      tick(1);
      chk("rst_hold_irq", 16'(a2_irq_oe_o), 16'd0);
      device_reset_n = 1'b1;
      #1;
      tick(1);
      chk("post_rst_wr", 16'(a2_irq_oe_o), 16'd1);
      bridge_wr_n_i = 1'b1;
      tick(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
